seven_seg_scan_ctrl: RTL and testbench
======================================

// Module: seven_seg_scan_ctrl
// PURPOSE
//  Parametrised time-multiplexed driver for an N-digit seven-segment display bank.
//  - Scans NUM_DIGITS digits, one digit slot per refresh period.
//  - Double-buffers the displayed value; a new value commits only at a frame boundary, so a frame never tears.
//  - Provides per-digit decimal points, leading-zero blanking and an inter-digit ghost-blanking gap.
//  - Sits between result/status logic (e.g. matrix-multiply outputs) and the board's anode/segment pins.
// PARAMETERS
//  NUM_DIGITS    8       number of digits scanned (2..16)
//  REFRESH_DIV   50000   clk cycles per digit slot (>= BLANK_CYCLES+2)
//  BLANK_CYCLES  16      cycles at the start of each slot with all anodes off
//  ACTIVE_LOW    1       1: anodes and segments are active-low; 0: active-high
//  BLINK_FRAMES  64      frames per blink half-period (used only with SEG_BLINK_EN)
// PORTS
//  clk          in   1              system clock
//  rst          in   1              asynchronous reset, active-high
//  load         in   1              1-cycle strobe: capture din/dp_in into the pending buffer
//  din          in   4*NUM_DIGITS   hex nibbles; nibble k drives digit k (digit 0 = rightmost)
//  dp_in        in   NUM_DIGITS     decimal-point enables, bit k -> digit k
//  lz_blank     in   1              1: blank leading zero digits (level, sampled every slot)
//  blink_mask   in   NUM_DIGITS     digits to blink (present only with SEG_BLINK_EN)
//  an           out  NUM_DIGITS     anode enables, an[k] -> digit k
//  seg          out  7              segments {g,f,e,d,c,b,a}
//  dp           out  1              decimal-point segment
//  busy         out  1              1 while a loaded value is pending commit
//  frame_tick   out  1              1-cycle pulse when the last digit slot of a frame ends
// BEHAVIOUR
//  - Reset (async assert, sync deassert): an, seg and dp at the OFF level; busy=0, frame_tick=0.
//    Slot counter=0, digit index=0, active and pending buffers = 0.
//  - OFF level is all-ones when ACTIVE_LOW=1, all-zeros otherwise. Polarity is applied only at the output registers.
//  - Slot counter runs 0..REFRESH_DIV-1 and wraps. Wrap is the slot end: the digit index increments,
//    and wraps from NUM_DIGITS-1 to 0.
//  - Frame boundary = slot end while index == NUM_DIGITS-1. frame_tick is high on that cycle only.
//  - Within a slot, at counter < BLANK_CYCLES: an = OFF.
//  - Otherwise: an = one-hot(index), with seg and dp taken from the active buffer for that digit.
//    an, seg and dp are registered together, so there is no anode/segment skew.
//  - load: pending <= {din, dp_in}; busy <= 1. A later load before commit overwrites pending (last wins).
//  - At a frame boundary with busy=1: active <= pending; busy <= 0.
//  - load on the same cycle as a frame boundary: active <= {din, dp_in} directly and busy stays 0.
//  - lz_blank=1 blanks every digit above the most significant nonzero nibble (seg and dp OFF).
//    Digit 0 is never blanked, so an all-zero value shows "0".
//  - Glyphs 0-9, A, b, C, d, E, F, with active-high patterns (a = bit0): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
//    8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
//  - Output latency: slot counter value to pins = 1 clk.
// CONFIGURATION
//  - SEG_BLINK_EN defined: adds the blink_mask port and a frame counter.
//    The counter toggles blink_phase every BLINK_FRAMES frame ticks and resets to phase 0.
//    While blink_phase=1, digits whose blink_mask bit is set drive seg and dp OFF; the anode still scans.
//  - SEG_BLINK_EN undefined: no blink_mask port, no frame counter, and no digit is ever blink-blanked.
// STRUCTURE
//  - Package seg7_pkg: glyph constant table (16 x 7-bit, active-high) and the OFF/ON polarity helper function.
//  - Sub-module seg7_glyph_decode: combinational 4-bit nibble -> 7-bit active-high glyph via seg7_pkg.
//  - Top module: slot counter, digit index, double buffer, blanking logic and output registers.
// TESTING  (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=1, BLINK_FRAMES=2)
//  - Reset mid-scan: an=4'b1111, seg=7'h7F, dp=1, busy=0 immediately, without a clk edge.
//    After release, the first lit slot is digit 0.
//  - load din=16'h12AF, dp_in=4'b0100: busy=1 until the next frame_tick, then 0.
//    Following frame: slot k shows F, A, 2 (dp lit), 1 on an=1110, 1101, 1011, 0111.
//  - Two loads (16'h1111 then 16'h2222) within one frame: the committed frame shows only 2222.
//  - load coincident with frame_tick: the new value appears from the very next slot, and busy never rises.
//  - lz_blank=1, din=16'h0030: digits 3 and 2 show seg=7F, digit 1 shows 3, digit 0 shows 0.
//    With din=0, only digit 0 shows 0.
//  - SEG_BLINK_EN, blink_mask=4'b0001: digit 0 is dark for 2 frames and lit for 2 frames, repeating.
//    Check each slot: an is OFF for 2 cycles, then one-hot for 6 cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// Glyph table and output-polarity helper shared by the seven-segment scan
// controller and its glyph decoder.
package seg7_pkg;

    // Active-high {g,f,e,d,c,b,a}, indexed by nibble value 0..F.
    localparam logic [15:0][6:0] GLYPH = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Map an internal "on" level to the pin level.
    function automatic logic pol(input logic on_lvl, input bit active_low);
        return on_lvl ^ active_low;
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Host/display bundle for seven_seg_scan_ctrl. SEG_BLINK_EN adds blink_mask.
interface seven_seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 8
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   din;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic                      lz_blank;
`ifdef SEG_BLINK_EN
    logic [NUM_DIGITS-1:0]     blink_mask;
`endif
    logic [NUM_DIGITS-1:0]     an;
    logic [6:0]                seg;
    logic                      dp;
    logic                      busy;
    logic                      frame_tick;

`ifdef SEG_BLINK_EN
    modport master (output load, din, dp_in, lz_blank, blink_mask,
                    input  an, seg, dp, busy, frame_tick);
    modport slave  (input  load, din, dp_in, lz_blank, blink_mask,
                    output an, seg, dp, busy, frame_tick);
`else
    modport master (output load, din, dp_in, lz_blank,
                    input  an, seg, dp, busy, frame_tick);
    modport slave  (input  load, din, dp_in, lz_blank,
                    output an, seg, dp, busy, frame_tick);
`endif
endinterface

// File: rtl/seg7_glyph_decode.sv
// Combinational hex nibble to active-high seven-segment glyph.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] glyph_o
);
    assign glyph_o = GLYPH[nib_i];
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed N-digit seven-segment driver with frame-synchronous double
// buffering. Define SEG_BLINK_EN to add blink_mask and the blink frame counter.
module seven_seg_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int ACTIVE_LOW   = 1,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                clk,
    input  logic                rst,
    seven_seg_scan_ctrl_if.slave io
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam bit AL    = (ACTIVE_LOW != 0);

    if (NUM_DIGITS < 2 || REFRESH_DIV < BLANK_CYCLES + 2 || BLINK_FRAMES < 1) begin : g_param_chk
        $error("seven_seg_scan_ctrl: illegal parameter combination");
    end

    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   act_din_q, act_din_d, pend_din_q, pend_din_d;
    logic [NUM_DIGITS-1:0]     act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic                      busy_q, busy_d;
    logic [NUM_DIGITS-1:0]     an_q, an_d, an_on;
    logic [6:0]                seg_q, seg_d, seg_on, glyph;
    logic                      dp_q, dp_d, dp_on;
    logic                      slot_end, frame_end, lit, dark, blink_off;
    logic [NUM_DIGITS-1:0]     zero_above;

    assign slot_end  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    assign frame_end = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign lit       = (cnt_q >= CNT_W'(BLANK_CYCLES));

    always_comb begin
        cnt_d = slot_end ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (slot_end)
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    // A load on the boundary cycle bypasses pending and lands in active directly.
    always_comb begin
        act_din_d  = act_din_q;
        act_dp_d   = act_dp_q;
        pend_din_d = pend_din_q;
        pend_dp_d  = pend_dp_q;
        busy_d     = busy_q;
        if (frame_end && busy_q) begin
            act_din_d = pend_din_q;
            act_dp_d  = pend_dp_q;
            busy_d    = 1'b0;
        end
        if (io.load) begin
            pend_din_d = io.din;
            pend_dp_d  = io.dp_in;
            if (frame_end) begin
                act_din_d = io.din;
                act_dp_d  = io.dp_in;
                busy_d    = 1'b0;
            end else begin
                busy_d    = 1'b1;
            end
        end
    end

    // zero_above[k]: digit k and everything above it are zero.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lz
        assign zero_above[k] = ~|act_din_q[4*NUM_DIGITS-1:4*k];
    end

    seg7_glyph_decode u_dec (
        .nib_i   (act_din_q[{idx_q, 2'b00} +: 4]),
        .glyph_o (glyph)
    );

`ifdef SEG_BLINK_EN
    localparam int FC_W = $clog2(BLINK_FRAMES + 1);
    logic [FC_W-1:0] fcnt_q;
    logic            phase_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt_q  <= '0;
            phase_q <= 1'b0;
        end else if (frame_end) begin
            if (fcnt_q == FC_W'(BLINK_FRAMES - 1)) begin
                fcnt_q  <= '0;
                phase_q <= ~phase_q;
            end else begin
                fcnt_q  <= fcnt_q + 1'b1;
            end
        end
    end

    assign blink_off = phase_q && io.blink_mask[idx_q];
`else
    assign blink_off = 1'b0;
`endif

    assign dark = (io.lz_blank && idx_q != '0 && zero_above[idx_q]) || blink_off;

    always_comb begin
        an_on  = '0;
        seg_on = '0;
        dp_on  = 1'b0;
        if (lit) begin
            an_on[idx_q] = 1'b1;
            if (!dark) begin
                seg_on = glyph;
                dp_on  = act_dp_q[idx_q];
            end
        end
        for (int k = 0; k < NUM_DIGITS; k++) an_d[k] = pol(an_on[k], AL);
        for (int k = 0; k < 7; k++)          seg_d[k] = pol(seg_on[k], AL);
        dp_d = pol(dp_on, AL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            act_din_q  <= '0;
            act_dp_q   <= '0;
            pend_din_q <= '0;
            pend_dp_q  <= '0;
            busy_q     <= 1'b0;
            an_q       <= {NUM_DIGITS{AL}};
            seg_q      <= {7{AL}};
            dp_q       <= AL;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            act_din_q  <= act_din_d;
            act_dp_q   <= act_dp_d;
            pend_din_q <= pend_din_d;
            pend_dp_q  <= pend_dp_d;
            busy_q     <= busy_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign io.an         = an_q;
    assign io.seg        = seg_q;
    assign io.dp         = dp_q;
    assign io.busy       = busy_q;
    assign io.frame_tick = frame_end;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl: 4 digits, 8-cycle slots, 2 blank cycles, active-low.
module tb_seven_seg_scan_ctrl;
    localparam int ND = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seven_seg_scan_ctrl_if #(.NUM_DIGITS(ND)) sif ();

    seven_seg_scan_ctrl #(
        .NUM_DIGITS(ND), .REFRESH_DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW(1), .BLINK_FRAMES(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (sif)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [3:0] obs_an   [192];
    logic [6:0] obs_seg  [192];
    logic       obs_dp   [192];
    logic       obs_busy [192];
    logic [6:0] es [4];
    logic       ed [4];

    // Pin-level expectations for scan step j of a frame started at counter 0.
    function automatic logic [3:0] e_an(input int j);
        logic [3:0] one;
        one = 4'b0001;
        return ((j % 8) < 2) ? 4'hF : ~(one << ((j / 8) % 4));
    endfunction
    function automatic logic [6:0] e_seg(input int j);
        return ((j % 8) < 2) ? 7'h7F : es[(j / 8) % 4];
    endfunction
    function automatic logic e_dp(input int j);
        return ((j % 8) < 2) ? 1'b1 : ed[(j / 8) % 4];
    endfunction

    task automatic capture(input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            obs_an[j]   = sif.an;
            obs_seg[j]  = sif.seg;
            obs_dp[j]   = sif.dp;
            obs_busy[j] = sif.busy;
        end
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (sif.frame_tick === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
        sif.din   = d;
        sif.dp_in = p;
        sif.load  = 1'b1;
        @(negedge clk);
        sif.load  = 1'b0;
    endtask

    task automatic test_reset;
        int n;
        rst = 1'b0;
        repeat (13) @(negedge clk);
        pulse_load(16'h4321, 4'b1010);
        #2 rst = 1'b1;
        #1;
        total++; if (sif.an !== 4'b1111) begin bad++; $display("FAIL rst_an got=%b want=1111", sif.an); end
        total++; if (sif.seg !== 7'h7F) begin bad++; $display("FAIL rst_seg got=%h want=7f", sif.seg); end
        total++; if (sif.dp !== 1'b1) begin bad++; $display("FAIL rst_dp got=%b want=1", sif.dp); end
        total++; if (sif.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", sif.busy); end
        total++; if (sif.frame_tick !== 1'b0) begin bad++; $display("FAIL rst_tick got=%b want=0", sif.frame_tick); end
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sif.an === 4'b1111 && n < 20);
        total++; if (n !== 3) begin bad++; $display("FAIL rst_first_lit_cycle got=%0d want=3", n); end
        total++; if (sif.an !== 4'b1110) begin bad++; $display("FAIL rst_first_digit got=%b want=1110", sif.an); end
        total++; if (sif.seg !== 7'h40) begin bad++; $display("FAIL rst_first_seg got=%h want=40", sif.seg); end
    endtask

    task automatic test_load;
        bit ok;
        wait_tick(ok);
        @(negedge clk);
        pulse_load(16'h12AF, 4'b0100);
        total++; if (sif.busy !== 1'b1) begin bad++; $display("FAIL load_busy_set got=%b want=1", sif.busy); end
        wait_tick(ok);
        total++; if (!ok) begin bad++; $display("FAIL load_tick_timeout got=0 want=1"); end
        total++; if (sif.busy !== 1'b1) begin bad++; $display("FAIL load_busy_at_tick got=%b want=1", sif.busy); end
        @(negedge clk);
        total++; if (sif.busy !== 1'b0) begin bad++; $display("FAIL load_busy_clear got=%b want=0", sif.busy); end
        es = '{7'h0E, 7'h08, 7'h24, 7'h79};
        ed = '{1'b1, 1'b1, 1'b0, 1'b1};
        capture(32);
        for (int j = 0; j < 32; j++) begin
            total++;
            if (obs_an[j] !== e_an(j) || obs_seg[j] !== e_seg(j) || obs_dp[j] !== e_dp(j)) begin
                bad++;
                $display("FAIL load_frame j=%0d an=%b/%b seg=%h/%h dp=%b/%b", j,
                         obs_an[j], e_an(j), obs_seg[j], e_seg(j), obs_dp[j], e_dp(j));
            end
        end
    endtask

    task automatic test_last_wins;
        bit ok;
        wait_tick(ok);
        @(negedge clk);
        pulse_load(16'h1111, 4'b0000);
        repeat (3) @(negedge clk);
        pulse_load(16'h2222, 4'b0000);
        wait_tick(ok);
        total++; if (!ok) begin bad++; $display("FAIL lastwins_tick_timeout got=0 want=1"); end
        @(negedge clk);
        es = '{7'h24, 7'h24, 7'h24, 7'h24};
        ed = '{1'b1, 1'b1, 1'b1, 1'b1};
        capture(32);
        for (int j = 0; j < 32; j++) begin
            total++;
            if (obs_an[j] !== e_an(j) || obs_seg[j] !== e_seg(j) || obs_dp[j] !== e_dp(j)) begin
                bad++;
                $display("FAIL lastwins_frame j=%0d an=%b/%b seg=%h/%h dp=%b/%b", j,
                         obs_an[j], e_an(j), obs_seg[j], e_seg(j), obs_dp[j], e_dp(j));
            end
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        wait_tick(ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_tick_timeout got=0 want=1"); end
        pulse_load(16'h5678, 4'b0001);
        total++; if (sif.busy !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%b want=0", sif.busy); end
        es = '{7'h00, 7'h78, 7'h02, 7'h12};
        ed = '{1'b0, 1'b1, 1'b1, 1'b1};
        capture(32);
        for (int j = 0; j < 32; j++) begin
            total++;
            if (obs_an[j] !== e_an(j) || obs_seg[j] !== e_seg(j) || obs_dp[j] !== e_dp(j) ||
                obs_busy[j] !== 1'b0) begin
                bad++;
                $display("FAIL b2b_frame j=%0d an=%b/%b seg=%h/%h dp=%b/%b busy=%b/0", j,
                         obs_an[j], e_an(j), obs_seg[j], e_seg(j), obs_dp[j], e_dp(j), obs_busy[j]);
            end
        end
    endtask

    task automatic test_lz_blank;
        bit ok;
        sif.lz_blank = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            wait_tick(ok);
            @(negedge clk);
            if (pass == 0) begin
                pulse_load(16'h0030, 4'b1100);
                es = '{7'h40, 7'h30, 7'h7F, 7'h7F};
                ed = '{1'b1, 1'b1, 1'b1, 1'b1};
            end else begin
                pulse_load(16'h0000, 4'b0001);
                es = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
                ed = '{1'b0, 1'b1, 1'b1, 1'b1};
            end
            wait_tick(ok);
            total++; if (!ok) begin bad++; $display("FAIL lz_tick_timeout pass=%0d got=0 want=1", pass); end
            @(negedge clk);
            capture(32);
            for (int j = 0; j < 32; j++) begin
                total++;
                if (obs_an[j] !== e_an(j) || obs_seg[j] !== e_seg(j) || obs_dp[j] !== e_dp(j)) begin
                    bad++;
                    $display("FAIL lz_frame pass=%0d j=%0d an=%b/%b seg=%h/%h dp=%b/%b", pass, j,
                             obs_an[j], e_an(j), obs_seg[j], e_seg(j), obs_dp[j], e_dp(j));
                end
            end
        end
        sif.lz_blank = 1'b0;
    endtask

`ifdef SEG_BLINK_EN
    task automatic test_blink;
        logic [6:0] exp_s;
        logic       exp_d;
        int         f;
        sif.blink_mask = 4'b0001;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        es = '{7'h40, 7'h40, 7'h40, 7'h40};
        ed = '{1'b1, 1'b1, 1'b1, 1'b1};
        capture(192);
        for (int j = 0; j < 192; j++) begin
            f     = j / 32;
            exp_s = e_seg(j);
            exp_d = e_dp(j);
            if ((j % 8) >= 2 && (j / 8) % 4 == 0 && (f == 2 || f == 3)) exp_s = 7'h7F;
            total++;
            if (obs_an[j] !== e_an(j) || obs_seg[j] !== exp_s || obs_dp[j] !== exp_d) begin
                bad++;
                $display("FAIL blink_frame f=%0d j=%0d an=%b/%b seg=%h/%h dp=%b/%b", f, j,
                         obs_an[j], e_an(j), obs_seg[j], exp_s, obs_dp[j], exp_d);
            end
        end
        sif.blink_mask = 4'b0000;
    endtask
`endif

    initial begin
        sif.load     = 1'b0;
        sif.din      = '0;
        sif.dp_in    = '0;
        sif.lz_blank = 1'b0;
`ifdef SEG_BLINK_EN
        sif.blink_mask = '0;
`endif
        repeat (3) @(negedge clk);
        test_reset();
        test_load();
        test_last_wins();
        test_back_to_back();
        test_lz_blank();
`ifdef SEG_BLINK_EN
        test_blink();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
